// File: rtl/quad_encoder_gen_pkg.sv
// Shared state encoding, quadrature phase tables and phase lookup for the
// two-pin encoder generator.
package quad_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] AB_REST = 2'b00;

  // AB pairs, A in bit 1; entry 3 is always the detent so every step ends at rest
  localparam logic [1:0] CW_SEQ  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [1:0] CCW_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] idx);
    return dir ? CW_SEQ[idx] : CCW_SEQ[idx];
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Step request handshake plus encoder pin / status outputs of the generator.
interface quad_encoder_gen_if #(
  parameter int POS_W = 8
);
  logic             step_valid;
  logic             step_dir;
  logic             step_ready;
  logic             enc_a;
  logic             enc_b;
  logic             busy;
  logic             step_done;
  logic [POS_W-1:0] position;

  modport master (
    output step_valid, step_dir,
    input  step_ready, enc_a, enc_b, busy, step_done, position
  );

  modport slave (
    input  step_valid, step_dir,
    output step_ready, enc_a, enc_b, busy, step_done, position
  );
endinterface

// File: rtl/quad_encoder_gen_timer.sv
// Per-phase dwell down-counter; flags phase end and whether the next cycle
// falls on an odd offset inside the contact-bounce window.
module quad_phase_timer import quad_encoder_pkg::*; #(
  parameter int DWELL_CYCLES   = 8,
  parameter int BOUNCE_TOGGLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic run_i,
  output logic phase_end_o,
  output logic glitch_next_o
);

  localparam int TW = $clog2(DWELL_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] next_off;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = TW'(DWELL_CYCLES - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = run_i && (cnt_q == '0);

  // Offset within the phase of the cycle the pins are being computed for
  assign next_off      = TW'(DWELL_CYCLES) - cnt_q;
  assign glitch_next_o = run_i && !start_i && next_off[0] &&
                         (int'(next_off) <= BOUNCE_TOGGLES);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B waveform generator: one detent step per accepted request,
// optional contact-bounce emulation, signed position counter.
//
// state | meaning
// IDLE  | pins at rest (00), step_ready high
// RUN   | walking the 4 phases of the latched direction
module quad_encoder_gen import quad_encoder_pkg::*; #(
  parameter int DWELL_CYCLES   = 8,
  parameter int BOUNCE_TOGGLES = 0,
  parameter int POS_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  quad_encoder_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [1:0]       ab_q, ab_d;
  logic             done_q, done_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic       accept;
  logic       tmr_run;
  logic       tmr_start;
  logic       phase_end;
  logic       glitch_next;
  logic [1:0] cur_ab;
  logic [1:0] prev_ab;

  assign accept    = (state_q == IDLE) && bus.step_valid;
  assign tmr_run   = (state_q == RUN);
  assign tmr_start = accept || (tmr_run && phase_end && (phase_q != 2'd3));

  // Phase 0's predecessor is index 3, which is the rest value
  assign cur_ab  = phase_ab(dir_q, phase_q);
  assign prev_ab = phase_ab(dir_q, phase_q - 2'd1);

  quad_phase_timer #(
    .DWELL_CYCLES   (DWELL_CYCLES),
    .BOUNCE_TOGGLES (BOUNCE_TOGGLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (tmr_start),
    .run_i         (tmr_run),
    .phase_end_o   (phase_end),
    .glitch_next_o (glitch_next)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          phase_d = 2'd0;
          dir_d   = bus.step_dir;
          ab_d    = phase_ab(bus.step_dir, 2'd0);
        end
      end
      RUN: begin
        if (phase_end) begin
          if (phase_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ab_d    = AB_REST;
            pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          end else begin
            phase_d = phase_q + 2'd1;
            ab_d    = phase_ab(dir_q, phase_q + 2'd1);
          end
        end else begin
          // Gray sequence: prev differs from cur only in the pin that just moved
          ab_d = glitch_next ? prev_ab : cur_ab;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      dir_q   <= 1'b0;
      ab_q    <= AB_REST;
      done_q  <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.step_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == RUN);
  assign bus.enc_a      = ab_q[1];
  assign bus.enc_b      = ab_q[0];
  assign bus.step_done  = done_q;
  assign bus.position   = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench: per-cycle reference model with a position scoreboard,
// a vector table for single steps, and directed multi-cycle sequences.
module tb_quad_encoder_gen;

  localparam int D0 = 4;
  localparam int B0 = 0;
  localparam int D1 = 6;
  localparam int B1 = 2;
  localparam int PW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_gen_if #(.POS_W(PW)) if0 ();
  quad_encoder_gen_if #(.POS_W(PW)) if1 ();

  quad_encoder_gen #(.DWELL_CYCLES(D0), .BOUNCE_TOGGLES(B0), .POS_W(PW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  quad_encoder_gen #(.DWELL_CYCLES(D1), .BOUNCE_TOGGLES(B1), .POS_W(PW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  logic [1:0] cw_tab  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] ccw_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_ab(input logic dir, input int off, input int d, input int b);
    int ph;
    int o;
    logic [1:0] cur;
    logic [1:0] prev;
    ph   = off / d;
    o    = off % d;
    cur  = dir ? cw_tab[ph] : ccw_tab[ph];
    prev = 2'b00;
    if (ph > 0) prev = dir ? cw_tab[ph-1] : ccw_tab[ph-1];
    return (o >= 1 && o <= b && (o % 2) == 1) ? prev : cur;
  endfunction

  // reference model state, one slot per DUT
  logic          m_act [2] = '{1'b0, 1'b0};
  int            m_p0  [2] = '{0, 0};
  logic          m_dir [2] = '{1'b0, 1'b0};
  logic [PW-1:0] m_pos [2] = '{8'h00, 8'h00};
  logic          armed [2] = '{1'b0, 1'b0};
  logic [PW-1:0] sbq0 [$];
  logic [PW-1:0] sbq1 [$];

  task automatic mon(input int u, input int d, input int b,
                     input logic a, input logic bb, input logic rdy, input logic bsy,
                     input logic dn, input logic [PW-1:0] pos, input logic vin, input logic din);
    logic [1:0]    e_ab;
    logic          e_rdy;
    logic          e_dn;
    logic [PW-1:0] sbv;
    int            off;
    e_ab  = 2'b00;
    e_rdy = 1'b1;
    e_dn  = 1'b0;
    if (m_act[u]) begin
      off = cyc - m_p0[u];
      if (off >= 4 * d) begin
        m_act[u] = 1'b0;
        e_dn     = 1'b1;
        m_pos[u] = m_dir[u] ? m_pos[u] + 8'd1 : m_pos[u] - 8'd1;
      end else begin
        e_ab  = exp_ab(m_dir[u], off, d, b);
        e_rdy = 1'b0;
      end
    end
    if (armed[u]) begin
      chk($sformatf("u%0d pins", u), 32'({a, bb}), 32'(e_ab));
      chk($sformatf("u%0d ready", u), 32'(rdy), 32'(e_rdy));
      chk($sformatf("u%0d busy", u), 32'(bsy), 32'(!e_rdy));
      chk($sformatf("u%0d done", u), 32'(dn), 32'(e_dn));
      chk($sformatf("u%0d position", u), 32'(pos), 32'(m_pos[u]));
      if (dn === 1'b1) begin
        if ((u == 0 && sbq0.size() == 0) || (u == 1 && sbq1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL u%0d scoreboard: step_done with no step pending (cycle %0d)", u, cyc);
        end else begin
          sbv = (u == 0) ? sbq0.pop_front() : sbq1.pop_front();
          chk($sformatf("u%0d sb position", u), 32'(pos), 32'(sbv));
        end
      end
    end
    if (rst_n === 1'b0) begin
      m_act[u] = 1'b0;
      m_pos[u] = '0;
      armed[u] = 1'b1;
      if (u == 0) sbq0.delete(); else sbq1.delete();
    end else if (armed[u] && e_rdy && vin === 1'b1) begin
      m_act[u] = 1'b1;
      m_p0[u]  = cyc + 1;
      m_dir[u] = din;
      sbv = din ? m_pos[u] + 8'd1 : m_pos[u] - 8'd1;
      if (u == 0) sbq0.push_back(sbv); else sbq1.push_back(sbv);
    end
  endtask

  always @(negedge clk) begin
    mon(0, D0, B0, if0.enc_a, if0.enc_b, if0.step_ready, if0.busy, if0.step_done,
        if0.position, if0.step_valid, if0.step_dir);
    mon(1, D1, B1, if1.enc_a, if1.enc_b, if1.step_ready, if1.busy, if1.step_done,
        if1.position, if1.step_valid, if1.step_dir);
  end

  function automatic logic rdy_of(input int u);
    return (u == 0) ? if0.step_ready : if1.step_ready;
  endfunction

  function automatic logic done_of(input int u);
    return (u == 0) ? if0.step_done : if1.step_done;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int u, input logic v, input logic dir);
    if (u == 0) begin
      if0.step_valid = v;
      if0.step_dir   = dir;
    end else begin
      if1.step_valid = v;
      if1.step_dir   = dir;
    end
  endtask

  // single step; returns the cycle in which phase 0 starts
  task automatic issue(input int u, input logic dir, output int p0);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    set_req(u, 1'b1, dir);
    while (!ok && n < 100) begin
      @(negedge clk);
      if (rdy_of(u) === 1'b1) ok = 1;
      @(posedge clk);
      #1;
      n++;
    end
    set_req(u, 1'b0, dir);
    p0 = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL u%0d accept timeout", u);
    end
  endtask

  task automatic wait_done(input int u);
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done_of(u) === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL u%0d step_done timeout", u);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input logic dir, input int n);
    int nacc;
    int cnt;
    nacc = 0;
    cnt  = 0;
    set_req(0, 1'b1, dir);
    while (nacc < n && cnt < n * 20 + 50) begin
      @(negedge clk);
      if (if0.step_ready === 1'b1) nacc++;
      @(posedge clk);
      #1;
      cnt++;
      if (nacc == n) if0.step_valid = 1'b0;
    end
    set_req(0, 1'b0, dir);
    chk("burst accept count", 32'(nacc), 32'(n));
    wait_done(0);
  endtask

  typedef struct {
    logic            rst;
    logic            dir;
    logic [3:0][1:0] ab;
    logic [7:0]      pos;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   p0;
    int   nacc;
    int   acc_t [3];
    logic b_exp [6];

    vecs[0] = '{rst: 1'b1, dir: 1'b1, ab: 8'b00_10_11_01, pos: 8'h01};
    vecs[1] = '{rst: 1'b1, dir: 1'b0, ab: 8'b00_01_11_10, pos: 8'hFF};
    vecs[2] = '{rst: 1'b0, dir: 1'b1, ab: 8'b00_10_11_01, pos: 8'h00};
    vecs[3] = '{rst: 1'b0, dir: 1'b1, ab: 8'b00_10_11_01, pos: 8'h01};
    vecs[4] = '{rst: 1'b0, dir: 1'b0, ab: 8'b00_01_11_10, pos: 8'h00};
    b_exp   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    set_req(0, 1'b0, 1'b0);
    set_req(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset pins", 32'({if0.enc_a, if0.enc_b}), 32'd0);
    chk("reset ready", 32'(if0.step_ready), 32'd1);
    chk("reset busy", 32'(if0.busy), 32'd0);
    chk("reset done", 32'(if0.step_done), 32'd0);
    chk("reset position", 32'(if0.position), 32'd0);
    @(posedge clk);
    #1;

    // single-step vector table on the DWELL=4, no-bounce instance
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rst) do_reset();
      issue(0, vecs[i].dir, p0);
      for (int k = 0; k < 4; k++) begin
        if (k == 0) @(negedge clk);
        else repeat (D0) @(negedge clk);
        chk($sformatf("vec%0d phase%0d pins", i, k), 32'({if0.enc_a, if0.enc_b}), 32'(vecs[i].ab[k]));
      end
      repeat (D0 - 1) @(negedge clk);
      chk($sformatf("vec%0d done early", i), 32'(if0.step_done), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d done", i), 32'(if0.step_done), 32'd1);
      chk($sformatf("vec%0d ready at done", i), 32'(if0.step_ready), 32'd1);
      chk($sformatf("vec%0d position", i), 32'(if0.position), 32'(vecs[i].pos));
      @(posedge clk);
      #1;
    end

    // step_valid held high, direction alternating CW/CCW/CW
    do_reset();
    set_req(0, 1'b1, 1'b1);
    nacc = 0;
    for (int n = 0; n < 200 && nacc < 3; n++) begin
      @(negedge clk);
      if (if0.step_ready === 1'b1) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc > 0) if0.step_dir = (nacc % 2 == 1) ? 1'b0 : 1'b1;
    end
    if0.step_valid = 1'b0;
    chk("b2b accept count", 32'(nacc), 32'd3);
    if (nacc == 3) begin
      chk("b2b spacing 1", 32'(acc_t[1] - acc_t[0]), 32'(4 * D0 + 1));
      chk("b2b spacing 2", 32'(acc_t[2] - acc_t[1]), 32'(4 * D0 + 1));
    end
    wait_done(0);
    chk("b2b final position", 32'(if0.position), 32'd1);

    // reset in the middle of a CW step: acceptance edge T, reset sampled at end of T+7
    issue(0, 1'b1, p0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    chk("abort busy before reset", 32'(if0.busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort pins", 32'({if0.enc_a, if0.enc_b}), 32'd0);
    chk("abort busy", 32'(if0.busy), 32'd0);
    chk("abort position", 32'(if0.position), 32'd0);
    @(posedge clk);
    #1;
    issue(0, 1'b1, p0);
    wait_done(0);
    chk("after abort position", 32'(if0.position), 32'd1);

    // bounce on the DWELL=6, BOUNCE=2 instance
    issue(1, 1'b1, p0);
    for (int o = 0; o < 6; o++) begin
      @(negedge clk);
      chk($sformatf("bounce B off%0d", o), 32'(if1.enc_b), 32'(b_exp[o]));
      chk($sformatf("bounce A off%0d", o), 32'(if1.enc_a), 32'd0);
    end
    repeat (18) @(negedge clk);
    chk("bounce done early", 32'(if1.step_done), 32'd0);
    @(negedge clk);
    chk("bounce done at P0+24", 32'(if1.step_done), 32'd1);
    chk("bounce position", 32'(if1.position), 32'd1);
    @(posedge clk);
    #1;
    issue(1, 1'b0, p0);
    wait_done(1);
    chk("bounce ccw position", 32'(if1.position), 32'd0);

    // position wrap
    do_reset();
    run_n(1'b1, 127);
    chk("wrap pos 7F", 32'(if0.position), 32'h7F);
    run_n(1'b1, 1);
    chk("wrap pos 80", 32'(if0.position), 32'h80);
    do_reset();
    run_n(1'b0, 129);
    chk("wrap ccw pos 7F", 32'(if0.position), 32'h7F);

    repeat (3) @(posedge clk);
    #1;
    chk("sb0 drained", 32'(sbq0.size()), 32'd0);
    chk("sb1 drained", 32'(sbq1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
